// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared types for the period meter.
// Holds the measurement FSM state encoding.
package period_meter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer plus rising-edge detector.
// Ports: clk, rst_n (async low), d (async in), rise (1-cycle pulse).
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures rising-edge-to-rising-edge interval of sig_in.
// Ports: clk, rst_n, sig_in, en in; period/overflow/period_valid out
// with period_ready handshake; dropped is a sticky lost-result flag.
module period_meter #(
   parameter  int MAX_CYCLES = 1000000,
   localparam int W          = $clog2(MAX_CYCLES + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         sig_in,
   input  logic         en,
   output logic [W-1:0] period,
   output logic         period_valid,
   input  logic         period_ready,
   output logic         overflow,
   output logic         dropped
);

   import period_meter_pkg::*;

   localparam logic [W-1:0] MAXV = W'(MAX_CYCLES);
   localparam logic [W-1:0] ONE  = W'(1);

   state_t       state;
   logic [W-1:0] count;
   logic         sat;
   logic         rise;
   logic         res_v;
   logic         load;

   sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sig_in),
      .rise  (rise)
   );

   // A result exists only for an edge that closes a measured interval.
   assign res_v = en && (state == MEASURE) && rise;
   // Output slot accepts when empty or being drained this cycle.
   assign load  = res_v && (!period_valid || period_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
         sat   <= 1'b0;
      end else if (!en) begin
         state <= IDLE;
         count <= '0;
         sat   <= 1'b0;
      end else begin
         unique case (1'b1)
            (state == IDLE): begin
               state <= ARM;
               count <= '0;
            end
            (state == ARM): begin
               if (rise) begin
                  state <= MEASURE;
                  count <= ONE;
               end
            end
            (state == MEASURE): begin
               if (rise) begin
                  count <= ONE;
                  sat   <= 1'b0;
               end else if (count >= MAXV - ONE) begin
                  // Saturate; the interval reached the limit.
                  count <= MAXV;
                  sat   <= 1'b1;
               end else begin
                  count <= count + ONE;
               end
            end
            default: begin
               state <= IDLE;
               count <= '0;
               sat   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period       <= '0;
         overflow     <= 1'b0;
         period_valid <= 1'b0;
         dropped      <= 1'b0;
      end else begin
         if (load) begin
            period       <= count;
            overflow     <= sat;
            period_valid <= 1'b1;
         end else if (period_ready) begin
            period_valid <= 1'b0;
         end
         if (!en) begin
            dropped <= 1'b0;
         end else if (res_v && period_valid && !period_ready) begin
            dropped <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed scoreboard bench for period_meter.
// Expected intervals come from bench-side edge timestamps.
module tb_period_meter;

   localparam int MAXC = 100;
   localparam int W    = $clog2(MAXC + 1);

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sig_in;
   logic         en;
   logic         period_ready;
   logic [W-1:0] period;
   logic         period_valid;
   logic         overflow;
   logic         dropped;

   logic [W:0] sb[$];
   int total  = 0;
   int passed = 0;
   int ncyc   = 0;
   int tprev  = 0;
   bit armed  = 1'b0;
   bit sb_on  = 1'b1;

   period_meter #(.MAX_CYCLES(MAXC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sig_in       (sig_in),
      .en           (en),
      .period       (period),
      .period_valid (period_valid),
      .period_ready (period_ready),
      .overflow     (overflow),
      .dropped      (dropped)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ncyc++;

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, int obs, int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
   endtask

   function automatic logic [W:0] exp_of(int gap);
      if (gap >= MAXC) return {1'b1, W'(MAXC)};
      return {1'b0, W'(gap)};
   endfunction

   // Rising edge now, then hold for gap cycles in total.
   task automatic step(int gap);
      if (armed && sb_on) sb.push_back(exp_of(ncyc - tprev));
      tprev  = ncyc;
      armed  = 1'b1;
      sig_in = 1'b1;
      cyc(gap / 2);
      sig_in = 1'b0;
      cyc(gap - gap / 2);
   endtask

   always @(negedge clk) begin
      if (rst_n && period_valid && period_ready) begin
         if (sb.size() == 0) begin
            total++;
            $error("FAIL xfer_unexpected obs=%0d exp=none", period);
         end else begin
            chk("xfer", int'({overflow, period}), int'(sb.pop_front()));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      en           = 1'b0;
      sig_in       = 1'b0;
      period_ready = 1'b1;
      #12;
      chk("rst_period", period, 0);
      chk("rst_valid", period_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_drop", dropped, 0);
      cyc(1);
      rst_n = 1'b1;
      cyc(1);
      en = 1'b1;
      cyc(3);

      repeat (5) step(10);
      step(150);
      step(20);
      step(99);
      step(100);
      step(20);
      step(40);
      chk("sb_drain1", sb.size(), 0);

      period_ready = 1'b0;
      step(10);
      chk("hold_valid", period_valid, 1);
      chk("hold_period", period, 40);
      chk("hold_drop0", dropped, 0);
      sb_on = 1'b0;
      step(10);
      chk("hold_period2", period, 40);
      chk("drop_set", dropped, 1);
      step(10);
      chk("hold_period3", period, 40);
      sb_on = 1'b1;
      period_ready = 1'b1;
      cyc(1);
      chk("xfer_valid0", period_valid, 0);
      chk("drop_sticky", dropped, 1);

      en = 1'b0;
      cyc(1);
      chk("drop_clr", dropped, 0);
      cyc(4);
      en = 1'b1;
      armed = 1'b0;
      cyc(3);
      step(10);
      step(15);
      step(25);
      step(10);
      chk("sb_drain2", sb.size(), 0);

      period_ready = 1'b0;
      step(30);
      chk("pend_period", period, 10);
      sb.push_back(exp_of(ncyc - tprev));
      tprev  = ncyc;
      sig_in = 1'b1;
      cyc(2);
      period_ready = 1'b1;
      cyc(1);
      period_ready = 1'b0;
      chk("same_valid", period_valid, 1);
      chk("same_period", period, 30);
      chk("same_drop", dropped, 0);
      cyc(2);
      sig_in = 1'b0;
      cyc(5);
      period_ready = 1'b1;
      cyc(1);
      chk("same_done", period_valid, 0);
      chk("sb_drain3", sb.size(), 0);

      period_ready = 1'b0;
      sb_on = 1'b0;
      step(10);
      step(10);
      chk("pre_rst_valid", period_valid, 1);
      chk("pre_rst_drop", dropped, 1);
      cyc(3);
      rst_n = 1'b0;
      #2;
      chk("arst_period", period, 0);
      chk("arst_valid", period_valid, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_drop", dropped, 0);
      cyc(2);
      rst_n = 1'b1;
      armed = 1'b0;
      sb_on = 1'b1;
      period_ready = 1'b1;
      cyc(3);
      step(10);
      chk("rearm_quiet", sb.size(), 0);
      step(12);
      step(10);
      chk("sb_drain4", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter MAX_CYCLES SHALL default to 1000000; it is the largest reportable period in clk cycles and is legal only when >= 2.
REQ-002 Derived constant W SHALL equal $clog2(MAX_CYCLES+1).
REQ-003 Port clk SHALL be an input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit, asynchronous active-low reset.
REQ-005 Port sig_in SHALL be an input, 1 bit, asynchronous square wave to measure (e.g. a blink output).
REQ-006 Port en SHALL be an input, 1 bit; high enables measurement.
REQ-007 Port period SHALL be an output, W bits, the measured rising-edge-to-rising-edge interval in clk cycles.
REQ-008 Port period_valid SHALL be an output, 1 bit, marking period/overflow as valid.
REQ-009 Port period_ready SHALL be an input, 1 bit, consumer acceptance.
REQ-010 Port overflow SHALL be an output, 1 bit, qualified by period_valid, set when the interval reached MAX_CYCLES.
REQ-011 Port dropped SHALL be an output, 1 bit, sticky flag that a result was lost.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer; a rising edge is detected in the cycle where the second flop is 1 and a delay flop holding its previous value is 0.
REQ-013 The FSM SHALL have states IDLE, ARM, MEASURE.
REQ-014 IDLE: en=1 -> ARM next cycle; count held at 0.
REQ-015 ARM: detected edge -> MEASURE with count loaded to 1; no result produced.
REQ-016 MEASURE: each cycle count <= min(count+1, MAX_CYCLES); the saturated condition sets an internal sat flag.
REQ-017 MEASURE with detected edge SHALL produce result (count, sat), reload count to 1, clear sat, and remain in MEASURE; edges at cycles t0, t1 yield period = t1-t0.
REQ-018 The result SHALL appear on period/overflow with period_valid=1 on the cycle after the detecting cycle (3 clk edges after the first clk edge sampling sig_in high).
REQ-019 en=0 in any state SHALL force IDLE next cycle, clear count and sat, and discard the partial measurement.
REQ-020 A pending output SHALL be retained across en=0 until handshaked.
REQ-021 The output register SHALL load a new result when period_valid=0, or when period_valid=1 and period_ready=1 in the same cycle.
REQ-022 While period_valid=1 and period_ready=0, period and overflow SHALL hold stable.
REQ-023 Transfer SHALL occur on a cycle with period_valid=1 and period_ready=1; period_valid deasserts next cycle unless a new result loads simultaneously.
REQ-024 A result arriving while the output is full and not being accepted SHALL be discarded and dropped set to 1.
REQ-025 dropped SHALL clear only on reset or while en=0.
REQ-026 sig_in pulses shorter than 2 clk periods are not guaranteed to be detected.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, count=0, sat=0, synchronizer/delay flops=0, period=0, period_valid=0, overflow=0, dropped=0.
REQ-028 The first edge after reset release SHALL only arm, never report.

Structure
REQ-029 The state enum typedef SHALL live in package period_meter_pkg.
REQ-030 The synchronizer and edge detector SHALL be sub-module sync_edge (ports clk, rst_n, d, rise).
REQ-031 Target size SHALL be 120-250 lines of RTL total.

Verification (MAX_CYCLES=100)
REQ-032 en=1, ready=1, sig_in rising every 10 cycles -> first edge no output, then period=10, overflow=0 per edge, valid one cycle each.
REQ-033 Edges 150 cycles apart -> period=100, overflow=1; next 20-cycle interval -> period=20, overflow=0.
REQ-034 ready=0, edges every 10 cycles -> period=10 held stable, later results discarded, dropped=1; ready=1 -> one transfer, then valid=0.
REQ-035 en dropped to 0 mid-interval for 5 cycles, then re-enabled -> next edge only arms; following interval reported correctly.
REQ-036 rst_n pulsed low mid-MEASURE with valid=1 -> all outputs 0 asynchronously; after release first edge does not report.
REQ-037 Result produced on the same cycle ready=1 accepts a pending one -> new value loads, valid stays 1, dropped stays 0.
